// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared image-geometry defaults and the pixel type used by the
//               line buffer and the downstream 3x3 neighbourhood stages.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int IMG_WIDTH      = 24;
    localparam int IMG_PIC_WIDTH  = 640;
    localparam int IMG_PIC_HEIGHT = 480;

    typedef logic [IMG_WIDTH-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/lb_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : lb_line_ram
// Description : Simple dual-port line RAM, read-first, 1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module lb_line_ram #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Contents are deliberately not reset; a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_3row
// Description : Two-line buffer producing vertically aligned (y-2, y-1, y)
//               pixel triples, one cycle after each accepted pixel.
//               Optional macro BORDER_REPLICATE_EN replicates the top border
//               instead of suppressing rows 0 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_3row
    import img_pkg::*;
#(
    parameter int WIDTH      = IMG_WIDTH,
    parameter int PIC_WIDTH  = IMG_PIC_WIDTH,
    parameter int PIC_HEIGHT = IMG_PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eol_out
);

    localparam int c_col_w = $clog2(PIC_WIDTH);
    localparam int c_row_w = $clog2(PIC_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(PIC_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(PIC_HEIGHT - 1);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_col_w-1:0] w_col;
    logic [c_row_w-1:0] w_row;
    logic [c_col_w-1:0] r_col_d1;
    logic               r_valid_d1;
    logic               r_vout;
    logic               r_eol;
    logic [WIDTH-1:0]   r_din_d1;
    logic [WIDTH-1:0]   w_a_rdata;
    logic [WIDTH-1:0]   w_b_rdata;
    logic [WIDTH-1:0]   w_tap1;
    logic [WIDTH-1:0]   w_tap2;
    logic [WIDTH-1:0]   w_tap3;
    logic [WIDTH-1:0]   r_hold1;
    logic [WIDTH-1:0]   r_hold2;
    logic [WIDTH-1:0]   r_hold3;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign w_col = sof_in ? '0 : r_col;
    assign w_row = sof_in ? '0 : r_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (sof_in) begin
                r_col <= c_col_w'(1);
                r_row <= '0;
            end else if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_row_last) ? '0 : r_row + c_row_w'(1);
            end else begin
                r_col <= r_col + c_col_w'(1);
            end
        end
    end

    // RAM A holds row y-1; its outgoing word is shifted into RAM B (row y-2) a cycle later.
    lb_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (PIC_WIDTH)
    ) u_ram_a (
        .clk       (clk),
        .i_wr_en   (valid_in),
        .i_wr_addr (w_col),
        .i_wr_data (din),
        .i_rd_en   (valid_in),
        .i_rd_addr (w_col),
        .o_rd_data (w_a_rdata)
    );

    lb_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (PIC_WIDTH)
    ) u_ram_b (
        .clk       (clk),
        .i_wr_en   (r_valid_d1),
        .i_wr_addr (r_col_d1),
        .i_wr_data (w_a_rdata),
        .i_rd_en   (valid_in),
        .i_rd_addr (w_col),
        .o_rd_data (w_b_rdata)
    );

`ifdef BORDER_REPLICATE_EN
    logic r_row0_d1;
    logic r_row1_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vout    <= 1'b0;
            r_row0_d1 <= 1'b0;
            r_row1_d1 <= 1'b0;
        end else begin
            r_vout    <= valid_in;
            r_row0_d1 <= (w_row == '0);
            r_row1_d1 <= (w_row == c_row_w'(1));
        end
    end

    always_comb begin
        w_tap3 = r_din_d1;
        w_tap2 = w_a_rdata;
        w_tap1 = w_b_rdata;
        if (r_row0_d1) begin
            w_tap2 = r_din_d1;
            w_tap1 = r_din_d1;
        end else if (r_row1_d1) begin
            w_tap1 = w_a_rdata;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vout <= 1'b0;
        end else begin
            r_vout <= valid_in && (w_row >= c_row_w'(2));
        end
    end

    always_comb begin
        w_tap3 = r_din_d1;
        w_tap2 = w_a_rdata;
        w_tap1 = w_b_rdata;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_d1 <= 1'b0;
            r_col_d1   <= '0;
            r_din_d1   <= '0;
            r_eol      <= 1'b0;
            r_hold1    <= '0;
            r_hold2    <= '0;
            r_hold3    <= '0;
        end else begin
            r_valid_d1 <= valid_in;
            r_col_d1   <= w_col;
            r_eol      <= (w_col == c_col_last);
            if (valid_in) begin
                r_din_d1 <= din;
            end
            if (r_vout) begin
                r_hold1 <= w_tap1;
                r_hold2 <= w_tap2;
                r_hold3 <= w_tap3;
            end
        end
    end

    // Live taps pass straight through on output cycles; otherwise the last triple is held.
    assign valid_out = r_vout;
    assign eol_out   = r_vout & r_eol;
    assign dout1     = r_vout ? w_tap1 : r_hold1;
    assign dout2     = r_vout ? w_tap2 : r_hold2;
    assign dout3     = r_vout ? w_tap3 : r_hold3;

endmodule
`default_nettype wire
